byte_serial_alu_ctrl: RTL and testbench

Sequencer that performs NBYTES-wide add, subtract and bitwise operations by time-multiplexing one 8-bit add/sub/logic slice, one byte per cycle, least-significant byte first. It chains carry and borrow between bytes and accumulates the result and flags. It sits between a valid/ready requester (e.g. a register-file or microcode stage) and the 8-bit datapath, so wide arithmetic costs no extra adders.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu8_slice.sv | 40 ++++
 rtl/byte_serial_alu_ctrl.sv | 152 +++++++++++++++
 tb/tb_byte_serial_alu_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the byte-serial ALU controller and its 8-bit slice.
//   NBYTES_DEFAULT : default operand width in bytes
//   OP_ADD..OP_XOR : request opcodes (5-7 are illegal)
//   aluState_e     : controller state encoding
//   isArith/isLogic: opcode class helpers
package alu_pkg;

  localparam int NBYTES_DEFAULT = 4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aluState_e;

  function automatic logic isArith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic isLogic(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/alu8_slice.sv
// Purely combinational 8-bit add/sub/logic slice.
//   op     in  3  opcode (ADD/SUB use the adder, AND/OR/XOR the logic unit)
//   a, b   in  8  byte operands
//   inC    in  1  carry in; when set, b is inverted before the add
//   result out 8  byte result (0 for illegal opcodes)
//   outC   out 1  adder carry out (0 for non-arithmetic opcodes)
module alu8_slice
  import alu_pkg::*;
(
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       inC,
  output logic [7:0] result,
  output logic       outC
);

  logic [7:0] bInt;
  logic [8:0] sum;

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    bInt   = b ^ {8{inC}};
    sum    = {1'b0, a} + {1'b0, bInt} + {8'd0, inC};
    result = 8'd0;
    outC   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result = sum[7:0];
        outC   = sum[8];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: ;
    endcase
  end

endmodule

// File: rtl/byte_serial_alu_ctrl.sv
// Byte-serial wide ALU sequencer: runs an NBYTES-wide ADD/SUB/AND/OR/XOR
// through one 8-bit slice, least-significant byte first, one byte per cycle.
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_op, req_a, req_b     opcode and operands
//   rsp_valid/rsp_ready      response handshake (valid only in DONE)
//   rsp_result               result word (also the result shift register)
//   rsp_carry, rsp_ovf       carry/no-borrow and signed overflow
//   rsp_zero, rsp_err        zero result, illegal opcode
module byte_serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [8*NBYTES-1:0]   req_a,
  input  logic [8*NBYTES-1:0]   req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_result,
  output logic                  rsp_carry,
  output logic                  rsp_ovf,
  output logic                  rsp_zero,
  output logic                  rsp_err
);

  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  aluState_e        state, stateNext;
  logic [2:0]       opReg;
  logic [W-1:0]     aReg, bReg;
  logic [IDX_W-1:0] idx;
  logic             carryReg;

  logic             accept, opArith, opLogic, opSub, lastByte;
  logic [7:0]       aByte, bByte, beff;
  logic             cin;
  logic [7:0]       sliceA, sliceB, sliceRes;
  logic             sliceInC, sliceOutC;
  logic [W-1:0]     nextRes;

  alu8_slice uSlice (
    .op     (opReg),
    .a      (sliceA),
    .b      (sliceB),
    .inC    (sliceInC),
    .result (sliceRes),
    .outC   (sliceOutC)
  );

  // Next-state logic.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        accept    = 1'b1;
        stateNext = RUN;
      end
      RUN:  if (idx == IDX_LAST) stateNext = DONE;
      DONE: if (rsp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Slice operand steering for the current byte.
  always_comb begin
    opArith  = isArith(opReg);
    opLogic  = isLogic(opReg);
    opSub    = (opReg == OP_SUB);
    lastByte = (idx == IDX_LAST);
    aByte    = aReg[7:0];
    bByte    = bReg[7:0];
    beff     = opSub ? ~bByte : bByte;
    cin      = (idx == '0) ? opSub : carryReg;
    sliceA   = 8'd0;
    sliceB   = 8'd0;
    sliceInC = 1'b0;
    if (opArith) begin
      sliceA   = aByte;
      // The slice re-inverts B whenever inC is set, so pre-invert here to
      // make the slice see exactly beff + cin.
      sliceB   = beff ^ {8{cin}};
      sliceInC = cin;
    end else if (opLogic) begin
      sliceA = aByte;
      sliceB = bByte;
    end
    // Result fills from the top so byte 0 lands at the bottom after NBYTES shifts.
    nextRes = {sliceRes, rsp_result[W-1:8]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      idx        <= '0;
      opReg      <= OP_ADD;
      aReg       <= '0;
      bReg       <= '0;
      carryReg   <= 1'b0;
    end else begin
      state     <= stateNext;
      req_ready <= (stateNext == IDLE);
      rsp_valid <= (stateNext == DONE);
      case (state)
        IDLE: if (accept) begin
          opReg      <= req_op;
          aReg       <= req_a;
          bReg       <= req_b;
          idx        <= '0;
          rsp_result <= '0;
          carryReg   <= 1'b0;
          rsp_carry  <= 1'b0;
          rsp_ovf    <= 1'b0;
          rsp_zero   <= 1'b0;
          rsp_err    <= 1'b0;
        end
        RUN: begin
          aReg       <= aReg >> 8;
          bReg       <= bReg >> 8;
          rsp_result <= nextRes;
          if (opArith) carryReg <= sliceOutC;
          if (lastByte) begin
            rsp_carry <= opArith & sliceOutC;
            rsp_ovf   <= opArith && (aByte[7] == beff[7]) && (sliceRes[7] != aByte[7]);
            rsp_zero  <= (opArith || opLogic) && (nextRes == '0);
            rsp_err   <= !(opArith || opLogic);
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_alu_ctrl.sv
// Self-checking bench for byte_serial_alu_ctrl (NBYTES=4): directed corner
// cases, a few random operations, back-pressure and mid-run reset.
module tb_byte_serial_alu_ctrl;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b, rsp_result;
  logic        rsp_carry, rsp_ovf, rsp_zero, rsp_err;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  byte_serial_alu_ctrl #(.NBYTES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_ovf    (rsp_ovf),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t  r;
    logic [32:0] wide;
    r = '{res: 32'd0, c: 1'b0, v: 1'b0, z: 1'b0, e: 1'b0};
    case (op)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        r.res = wide[31:0];
        r.c   = wide[32];
        r.v   = (a[31] == b[31]) && (r.res[31] != a[31]);
      end
      OP_SUB: begin
        r.res = a - b;
        r.c   = (a >= b);
        r.v   = (a[31] != b[31]) && (r.res[31] != a[31]);
      end
      OP_AND: r.res = a & b;
      OP_OR:  r.res = a | b;
      OP_XOR: r.res = a ^ b;
      default: r.e = 1'b1;
    endcase
    if (!r.e) r.z = (r.res == 32'd0);
    return r;
  endfunction

  // Caller is positioned at a falling edge.
  task automatic startReq(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    sb.push_back(modelOp(op, a, b));
  endtask

  task automatic waitAccept(output int waited);
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("acceptReady", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic waitRsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
  endtask

  task automatic checkRsp(input string tag);
    exp_t e;
    check({tag, "_sbNonEmpty"}, {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_valid"},  {31'd0, rsp_valid}, 32'd1);
      check({tag, "_result"}, rsp_result, e.res);
      check({tag, "_flags"},  {28'd0, rsp_carry, rsp_ovf, rsp_zero, rsp_err},
                              {28'd0, e.c, e.v, e.z, e.e});
      check({tag, "_reqReady"}, {31'd0, req_ready}, 32'd0);
    end
  endtask

  task automatic finishRsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int waited, lat;
    @(negedge clk);
    startReq(op, a, b);
    waitAccept(waited);
    waitRsp(lat);
    check({tag, "_latency"}, 32'(lat), 32'd5);
    checkRsp(tag);
    finishRsp();
  endtask

  initial begin
    int          waited, lat, seen;
    logic [31:0] snapRes;
    logic [3:0]  snapFlags;

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = 3'd0; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    check("rst_reqReady",  {31'd0, req_ready}, 32'd1);
    check("rst_rspValid",  {31'd0, rsp_valid}, 32'd0);
    check("rst_result",    rsp_result, 32'd0);
    check("rst_flags",     {28'd0, rsp_carry, rsp_ovf, rsp_zero, rsp_err}, 32'd0);
    rst = 1'b0;

    runOp("addCarry8",  OP_ADD, 32'h0000_00FF, 32'h0000_0001);
    runOp("subBorrow",  OP_SUB, 32'h0000_0000, 32'h0000_0001);
    runOp("subOvf",     OP_SUB, 32'h8000_0000, 32'h0000_0001);
    runOp("addOvf",     OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    runOp("addWrap",    OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    runOp("xor",        OP_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000);
    runOp("and",        OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
    runOp("orZero",     OP_OR,  32'h0000_0000, 32'h0000_0000);
    runOp("illegal6",   3'd6,   32'h1234_5678, 32'h1111_1111);
    for (int i = 0; i < 8; i++)
      runOp("rand", 3'($urandom_range(0, 7)), $urandom, $urandom);

    // Back-pressure: rsp_ready low for 3 cycles with a second request pending.
    @(negedge clk);
    startReq(OP_ADD, 32'h1234_5678, 32'h0FED_CBA9);
    waitAccept(waited);
    waitRsp(lat);
    check("bp1_latency", 32'(lat), 32'd5);
    snapRes   = rsp_result;
    snapFlags = {rsp_carry, rsp_ovf, rsp_zero, rsp_err};
    checkRsp("bp1");
    @(negedge clk);
    startReq(OP_SUB, 32'h0000_0010, 32'h0000_0020);
    for (int i = 0; i < 2; i++) begin
      check("bp_stableRes",   rsp_result, snapRes);
      check("bp_stableFlags", {28'd0, rsp_carry, rsp_ovf, rsp_zero, rsp_err}, {28'd0, snapFlags});
      check("bp_rspValid",    {31'd0, rsp_valid}, 32'd1);
      check("bp_reqReady",    {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    check("bp_stableRes3", rsp_result, snapRes);
    finishRsp();
    @(negedge clk);
    waitAccept(waited);
    check("bp_acceptNext", 32'(waited), 32'd0);
    waitRsp(lat);
    check("bp2_latency", 32'(lat), 32'd5);
    checkRsp("bp2");
    finishRsp();

    // Reset in the second RUN cycle abandons the operation.
    @(negedge clk);
    startReq(OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitAccept(waited);
    void'(sb.pop_back());
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midRst_reqReady", {31'd0, req_ready}, 32'd1);
    check("midRst_rspValid", {31'd0, rsp_valid}, 32'd0);
    check("midRst_result",   rsp_result, 32'd0);
    check("midRst_flags",    {28'd0, rsp_carry, rsp_ovf, rsp_zero, rsp_err}, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("midRst_noRsp", 32'(seen), 32'd0);
    runOp("postRstAdd", OP_ADD, 32'h0000_0002, 32'h0000_0003);

    check("sbDrained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
